// File: rtl/text_row_fetcher_pkg.sv
// Shared constants, FSM encoding and the cell address map used by both
// the terminal stream writer and this row fetcher.
package text_row_fetcher_pkg;

    localparam logic TRUE    = 1'b1;
    localparam logic FALSE   = 1'b0;
    localparam logic TRUE_n  = 1'b0;
    localparam logic FALSE_n = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQUEST = 2'd1,
        ST_RECEIVE = 2'd2,
        ST_FINISH  = 2'd3
    } fetch_state_t;

    // 128-cell stride per row, 4-byte cells, 23-bit SDRAM word address
    function automatic logic [22:0] cell_address(input logic [5:0] y, input logic [6:0] x);
        return {8'b0, y, x, 2'b00};
    endfunction

endpackage

// File: rtl/text_row_fetcher_if.sv
// SDRAM controller read port as seen by the row fetcher (master) and the
// controller (slave).
interface text_row_fetcher_if;
    logic [22:0] rd_address;
    logic        rd_request;
    logic [8:0]  rd_burst_length;
    logic [31:0] rd_data;
    logic        rd_data_available;
    logic        rd_done;

    modport master (
        output rd_address, rd_request, rd_burst_length,
        input  rd_data, rd_data_available, rd_done
    );

    modport slave (
        input  rd_address, rd_request, rd_burst_length,
        output rd_data, rd_data_available, rd_done
    );
endinterface

// File: rtl/text_row_fetcher_cell_line_buffer.sv
// Ping-pong line buffer (cell_line_buffer): 2 banks x 128 cells x 32 bits,
// one write port and one registered read port.
module text_row_fetcher_cell_line_buffer (
    input  logic        clk,
    input  logic        wr_en,
    input  logic        wr_bank,
    input  logic [6:0]  wr_idx,
    input  logic [31:0] wr_data,
    input  logic        rd_bank,
    input  logic [6:0]  rd_idx,
    output logic [31:0] rd_data
);

    logic [31:0] mem [0:255];
    logic [31:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{wr_bank, wr_idx}] <= wr_data;
        end
        rd_data_q <= mem[{rd_bank, rd_idx}];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/text_row_fetcher.sv
// Fetches one text row from SDRAM into the back half of a ping-pong line
// buffer while the character generator reads the front half.
module text_row_fetcher
    import text_row_fetcher_pkg::*;
#(
    parameter int COLUMNS = 80,
    parameter int ROWS    = 51
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [5:0]          fetch_row,
    input  logic                fetch_start,
    output logic                busy,
    output logic                fetch_done,
    output logic                underrun,
    input  logic                swap,
    input  logic [6:0]          cell_x,
    output logic [31:0]         cell_data,
    text_row_fetcher_if.master  rd
);

    localparam logic [7:0] COLS_W  = 8'(COLUMNS);
    localparam logic [6:0] ROWS_W  = 7'(ROWS);
    localparam logic [8:0] BURST_W = 9'(COLUMNS);

    fetch_state_t state_q, state_d;
    logic [7:0]   count_q, count_d;
    logic         front_sel_q, front_sel_d;
    logic         busy_q, busy_d;
    logic         fetch_done_q, fetch_done_d;
    logic         underrun_q, underrun_d;
    logic         rd_request_q, rd_request_d;
    logic [22:0]  rd_address_q, rd_address_d;
    logic [8:0]   rd_burst_length_q, rd_burst_length_d;
    logic         data_zero_q, data_zero_d;
    logic         wr_en;
    logic [31:0]  buf_rd_data;

    always_comb begin
        state_d           = state_q;
        count_d           = count_q;
        front_sel_d       = front_sel_q;
        busy_d            = busy_q;
        fetch_done_d      = FALSE;
        underrun_d        = FALSE;
        rd_request_d      = FALSE;
        rd_address_d      = rd_address_q;
        rd_burst_length_d = rd_burst_length_q;
        wr_en             = FALSE;
        data_zero_d       = ({1'b0, cell_x} >= COLS_W);

        // Swapping while filling would expose a half-written row on screen
        if (swap && (state_q == ST_IDLE || state_q == ST_FINISH)) begin
            front_sel_d = ~front_sel_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (fetch_start && ({1'b0, fetch_row} < ROWS_W)) begin
                    state_d           = ST_REQUEST;
                    count_d           = '0;
                    busy_d            = TRUE;
                    rd_request_d      = TRUE;
                    rd_address_d      = cell_address(fetch_row, 7'd0);
                    rd_burst_length_d = BURST_W;
                end
            end
            ST_REQUEST: begin
                state_d = ST_RECEIVE;
            end
            ST_RECEIVE: begin
                if (rd.rd_data_available && (count_q < COLS_W)) begin
                    wr_en   = TRUE;
                    count_d = count_q + 8'd1;
                end
                if (rd.rd_done) begin
                    state_d      = ST_FINISH;
                    fetch_done_d = TRUE;
                    underrun_d   = (count_d < COLS_W);
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
                busy_d  = FALSE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = FALSE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q           <= ST_IDLE;
            count_q           <= '0;
            front_sel_q       <= FALSE;
            busy_q            <= FALSE;
            fetch_done_q      <= FALSE;
            underrun_q        <= FALSE;
            rd_request_q      <= FALSE;
            rd_address_q      <= '0;
            rd_burst_length_q <= BURST_W;
            data_zero_q       <= TRUE;
        end else begin
            state_q           <= state_d;
            count_q           <= count_d;
            front_sel_q       <= front_sel_d;
            busy_q            <= busy_d;
            fetch_done_q      <= fetch_done_d;
            underrun_q        <= underrun_d;
            rd_request_q      <= rd_request_d;
            rd_address_q      <= rd_address_d;
            rd_burst_length_q <= rd_burst_length_d;
            data_zero_q       <= data_zero_d;
        end
    end

    // Write and read banks are always opposite, so fills never disturb the display
    text_row_fetcher_cell_line_buffer u_line_buffer (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_bank (~front_sel_q),
        .wr_idx  (count_q[6:0]),
        .wr_data (rd.rd_data),
        .rd_bank (front_sel_q),
        .rd_idx  (cell_x),
        .rd_data (buf_rd_data)
    );

    // RAM output is not reset, so the zero flag also covers the reset value
    assign cell_data          = data_zero_q ? 32'd0 : buf_rd_data;
    assign busy               = busy_q;
    assign fetch_done         = fetch_done_q;
    assign underrun           = underrun_q;
    assign rd.rd_request      = rd_request_q;
    assign rd.rd_address      = rd_address_q;
    assign rd.rd_burst_length = rd_burst_length_q;

endmodule
